// File: rtl/image_pkg.sv
// Shared image constants and the readback FSM state type, used by both the write buffer and the
// readback streamer.
package image_pkg;

  localparam int unsigned IMG_WIDTH  = 30;
  localparam int unsigned IMG_HEIGHT = 30;
  // 900 pixel bits padded up to a whole number of bytes
  localparam int unsigned TOTAL_BITS = 904;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned NUM_BYTES  = TOTAL_BITS / BYTE_W;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StCsum,
    StDone
  } rb_state_e;

endpackage

// File: rtl/image_readback_streamer.sv
// Streams a snapshot of the flattened image out as bytes on a valid/ready link.
// Define IMG_READBACK_CHECKSUM_EN to append an XOR checksum byte after the image.
module image_readback_streamer #(
  parameter int unsigned TOTAL_BITS = image_pkg::TOTAL_BITS
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start_i,
  input  logic                                 abort_i,
  input  logic                                 img_valid_i,
  input  logic [TOTAL_BITS-1:0]                img_in_i,
  output logic [7:0]                           tx_data_o,
  output logic                                 tx_valid_o,
  input  logic                                 tx_ready_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 err_not_ready_o,
  output logic [$clog2(TOTAL_BITS/8+1)-1:0]    byte_idx_o
);
  import image_pkg::*;

  localparam int unsigned NUM_BYTES = TOTAL_BITS / 8;
  localparam int unsigned IDX_W     = $clog2(NUM_BYTES + 1);

  rb_state_e             state_q, state_d;
  logic [TOTAL_BITS-1:0] shadow_q, shadow_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  err_q, err_d;
  logic                  last_byte;

`ifdef IMG_READBACK_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
`endif

  assign last_byte = (idx_q == IDX_W'(NUM_BYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      shadow_q <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
`ifdef IMG_READBACK_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
`ifdef IMG_READBACK_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    err_d    = 1'b0;
`ifdef IMG_READBACK_CHECKSUM_EN
    csum_d   = csum_q;
`endif

    if (abort_i) begin
      // Abort wins over start and over a same-cycle transfer.
      state_d = StIdle;
      idx_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            if (img_valid_i) begin
              shadow_d = img_in_i;
              idx_d    = '0;
`ifdef IMG_READBACK_CHECKSUM_EN
              csum_d   = '0;
`endif
              state_d  = StStream;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        StStream: begin
          if (tx_ready_i) begin
            // Shift the snapshot so the presented byte is always the low slice.
            shadow_d = shadow_q >> 8;
`ifdef IMG_READBACK_CHECKSUM_EN
            csum_d   = csum_q ^ shadow_q[7:0];
            if (last_byte) begin
              idx_d   = IDX_W'(NUM_BYTES);
              state_d = StCsum;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
`else
            if (last_byte) begin
              idx_d   = '0;
              state_d = StDone;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
`endif
          end
        end
`ifdef IMG_READBACK_CHECKSUM_EN
        StCsum: begin
          if (tx_ready_i) begin
            idx_d   = '0;
            state_d = StDone;
          end
        end
`endif
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    tx_data_o  = '0;
    tx_valid_o = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    case (state_q)
      StStream: begin
        tx_data_o  = shadow_q[7:0];
        tx_valid_o = 1'b1;
        busy_o     = 1'b1;
      end
`ifdef IMG_READBACK_CHECKSUM_EN
      StCsum: begin
        tx_data_o  = csum_q;
        tx_valid_o = 1'b1;
        busy_o     = 1'b1;
      end
`endif
      StDone: begin
        done_o = 1'b1;
      end
      default: begin
        tx_valid_o = 1'b0;
      end
    endcase
  end

  assign byte_idx_o      = idx_q;
  assign err_not_ready_o = err_q;

endmodule

// File: tb/tb_image_readback_streamer.sv
// Self-checking bench for image_readback_streamer: table of stream runs checked through a
// byte scoreboard, plus hand-written error, abort and reset sequences.
module tb_image_readback_streamer;
  import image_pkg::*;

  localparam int NB = 113;
  localparam int IW = $clog2(NB + 1);
`ifdef IMG_READBACK_CHECKSUM_EN
  localparam int EXP_LEN = NB + 1;
`else
  localparam int EXP_LEN = NB;
`endif

  logic                  clk;
  logic                  rst_n;
  logic                  start;
  logic                  abort;
  logic                  img_valid;
  logic [TOTAL_BITS-1:0] img_in;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  busy;
  logic                  done;
  logic                  err_not_ready;
  logic [IW-1:0]         byte_idx;

  image_readback_streamer #(
    .TOTAL_BITS (TOTAL_BITS)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start),
    .abort_i         (abort),
    .img_valid_i     (img_valid),
    .img_in_i        (img_in),
    .tx_data_o       (tx_data),
    .tx_valid_o      (tx_valid),
    .tx_ready_i      (tx_ready),
    .busy_o          (busy),
    .done_o          (done),
    .err_not_ready_o (err_not_ready),
    .byte_idx_o      (byte_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned mul;
    int unsigned add;
    logic [3:0]  rdy_pat;
    bit          clobber;
    int          exp_len;
  } vec_t;

  typedef struct {
    logic [7:0]    data;
    logic [IW-1:0] idx;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
  endtask

  // One readback: load image byte k = k*mul+add, start, then drain through the scoreboard.
  // ab_at / rst_at >= 0 abort or reset while that byte index is presented.
  task automatic run_stream(input int unsigned mul, input int unsigned add,
                            input logic [3:0] pat, input bit clobber,
                            input int ab_at, input int rst_at, input int exp_len);
    logic [7:0] b;
    logic [7:0] csum;
    int         cyc;
    int         nxfer;
    bit         stop;
    sb.delete();
    csum = 8'h00;
    for (int k = 0; k < NB; k++) begin
      b = 8'(k * mul + add);
      img_in[8*k +: 8] = b;
      sb.push_back('{data: b, idx: IW'(k)});
      csum ^= b;
    end
`ifdef IMG_READBACK_CHECKSUM_EN
    sb.push_back('{data: csum, idx: IW'(NB)});
`endif
    @(negedge clk);
    img_valid = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("first_valid", 32'(tx_valid), 32'd1);
    check("first_busy", 32'(busy), 32'd1);
    if (clobber) begin
      img_in    = '1;
      img_valid = 1'b0;
    end
    cyc   = 0;
    nxfer = 0;
    stop  = 1'b0;
    while (sb.size() > 0 && !stop) begin
      start = 1'b0;
      if (cyc >= 2000) begin
        check("stream_timeout", 32'd0, 32'd1);
        stop = 1'b1;
      end else begin
        tx_ready = pat[cyc % 4];
        check("valid", 32'(tx_valid), 32'd1);
        check("data", 32'(tx_data), 32'(sb[0].data));
        check("idx", 32'(byte_idx), 32'(sb[0].idx));
        check("no_err_busy", 32'(err_not_ready), 32'd0);
        if (nxfer == 10) start = 1'b1;  // start while busy must be ignored
        if (nxfer == ab_at) begin
          abort    = 1'b1;
          tx_ready = 1'b1;
        end
        if (nxfer == rst_at) begin
          rst_n = 1'b0;
          #1;
          check("rst_tx_data", 32'(tx_data), 32'd0);
          check("rst_byte_idx", 32'(byte_idx), 32'd0);
          check("rst_err", 32'(err_not_ready), 32'd0);
          check_idle_outputs("rst");
          stop = 1'b1;
        end else if (tx_ready) begin
          void'(sb.pop_front());
          nxfer++;
          if (abort) stop = 1'b1;
        end
        cyc++;
        @(negedge clk);
      end
    end
    tx_ready = 1'b0;
    start    = 1'b0;
    if (rst_at >= 0) begin
      rst_n = 1'b1;
      @(negedge clk);
      check_idle_outputs("post_rst");
    end else if (ab_at >= 0) begin
      abort = 1'b0;
      check("abort_count", 32'(nxfer), 32'(ab_at + 1));
      check_idle_outputs("abort");
      @(negedge clk);
      check_idle_outputs("abort_after");
    end else begin
      check("xfer_count", 32'(nxfer), 32'(exp_len));
      check("done_pulse", 32'(done), 32'd1);
      check("done_busy", 32'(busy), 32'd0);
      check("done_valid", 32'(tx_valid), 32'd0);
      @(negedge clk);
      check_idle_outputs("after_done");
      check("after_done_idx", 32'(byte_idx), 32'd0);
    end
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{mul: 1,   add: 0, rdy_pat: 4'b1111, clobber: 1'b0, exp_len: EXP_LEN};
    vecs[1] = '{mul: 1,   add: 0, rdy_pat: 4'b1001, clobber: 1'b0, exp_len: EXP_LEN};
    vecs[2] = '{mul: 1,   add: 0, rdy_pat: 4'b1111, clobber: 1'b1, exp_len: EXP_LEN};
    vecs[3] = '{mul: 37,  add: 5, rdy_pat: 4'b0110, clobber: 1'b0, exp_len: EXP_LEN};
    vecs[4] = '{mul: 255, add: 3, rdy_pat: 4'b1011, clobber: 1'b1, exp_len: EXP_LEN};

    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    img_valid = 1'b0;
    img_in    = '0;
    tx_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx_data", 32'(tx_data), 32'd0);
    check("reset_idx", 32'(byte_idx), 32'd0);
    check("reset_err", 32'(err_not_ready), 32'd0);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    // Start without a valid image: single error pulse, nothing streams.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("err_pulse", 32'(err_not_ready), 32'd1);
    check_idle_outputs("err");
    @(negedge clk);
    check("err_clear", 32'(err_not_ready), 32'd0);
    check_idle_outputs("err_after");

    // Abort beats start in the same cycle.
    img_valid = 1'b1;
    start     = 1'b1;
    abort     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_idle_outputs("abort_vs_start");
    check("abort_vs_start_err", 32'(err_not_ready), 32'd0);

    for (int i = 0; i < 5; i++) begin
      run_stream(vecs[i].mul, vecs[i].add, vecs[i].rdy_pat, vecs[i].clobber, -1, -1,
                 vecs[i].exp_len);
    end

    run_stream(1, 0, 4'b1111, 1'b0, 50, -1, EXP_LEN);
    run_stream(1, 0, 4'b1111, 1'b0, -1, -1, EXP_LEN);
    run_stream(1, 0, 4'b1111, 1'b0, -1, 20, EXP_LEN);
    run_stream(3, 7, 4'b1001, 1'b0, -1, -1, EXP_LEN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/image_readback_streamer.md
Name: image_readback_streamer

Overview:
- Reads a completed flattened image back out as a byte stream, the read-side counterpart of the image write buffer.
- Used for host readback/debug of the captured image over the byte link (SPI/UART TX path).
- On start, snapshots the TOTAL_BITS image vector, then emits NUM_BYTES bytes on a valid/ready handshake.
- Byte k = img_in[8k +: 8], with bit 7 of the byte taken from the MSB end of the slice. This matches the write-side byte mapping exactly.

Parameters:
- TOTAL_BITS, 904, width of the flattened image vector; must be a multiple of 8.
- NUM_BYTES, TOTAL_BITS/8 (113), localparam; bytes per image.
- IDX_W, $clog2(NUM_BYTES+1) (7), localparam; byte index width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset: asynchronous, active-low.
- start  input  1  request readback; sampled in IDLE only.
- abort  input  1  cancel the stream; returns to IDLE.
- img_valid  input  1  image complete (driven from buffer full flag).
- img_in  input  TOTAL_BITS  flattened image from the buffer.
- tx_data  output  8  current byte.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  sink accepts the byte.
- busy  output  1  stream in progress.
- done  output  1  one-cycle pulse after the final byte is accepted.
- err_not_ready  output  1  one-cycle pulse when start arrives with img_valid=0.
- byte_idx  output  IDX_W  index of the byte currently presented.

Behaviour:
- Reset: state IDLE, shadow register=0, index=0. All outputs 0: tx_data, tx_valid, busy, done, err_not_ready, byte_idx.
- States: IDLE -> STREAM -> (CSUM when the optional feature is compiled in) -> DONE -> IDLE.

IDLE:
- start && img_valid && !abort: shadow <= img_in, idx <= 0, go to STREAM.
- start && !img_valid: err_not_ready=1 for exactly one cycle; stay in IDLE.

STREAM:
- busy=1, tx_valid=1, tx_data=shadow byte idx.
- First tx_valid appears 1 cycle after the start cycle.
- Transfer happens on tx_valid && tx_ready.
  - idx < NUM_BYTES-1: idx increments.
  - idx == NUM_BYTES-1: go to DONE (or CSUM).
- Full throughput: one byte per cycle while tx_ready=1.
- tx_data and byte_idx hold stable while tx_valid && !tx_ready; tx_valid never drops without a transfer, except on abort or reset.
- Recommended implementation: the shadow shifts right 8 bits per transfer and tx_data = shadow[7:0]; this avoids a 904:1 mux. byte_idx is kept as a separate counter.

DONE:
- Lasts one cycle: done=1, busy=0, tx_valid=0; then IDLE.
- A start in this cycle is ignored.

Boundaries and priorities:
- Snapshot isolation: changes to img_in or img_valid after the start cycle (including buffer clear) do not affect the stream.
- start while busy is ignored; no error pulse.
- abort from any state: IDLE next cycle, tx_valid=0, busy=0, no done pulse.
  - abort beats start in the same cycle.
  - abort beats a transfer in the same cycle; that byte still counts as accepted by the sink, but no further bytes follow.
- Reset mid-stream: immediate return to reset values; no done pulse.
- Restart after abort or done always begins at byte 0 from a fresh snapshot.

Optional Feature:
- Macro: IMG_READBACK_CHECKSUM_EN.
- Defined:
  - A running XOR of every transferred byte is accumulated; the accumulator is cleared at snapshot.
  - After the final image byte, state CSUM presents the XOR as byte NUM_BYTES, with byte_idx=NUM_BYTES and the same handshake rules.
  - DONE follows its transfer.
  - Total of 114 bytes.
- Undefined: no accumulator and no CSUM state; exactly NUM_BYTES bytes.

Decomposition:
- Shared package image_pkg holds IMG_WIDTH=30, IMG_HEIGHT=30, TOTAL_BITS=904, BYTE_W=8, NUM_BYTES=113.
- Readback state enum (IDLE, STREAM, CSUM, DONE) also lives in image_pkg; the write buffer shares the constants.
- No sub-module: the shift/index/FSM logic is small and tightly coupled. Single module.

Test Plan:
- Reset, then img_in byte k = k (k=0..112), img_valid=1, 1-cycle start, tx_ready=1 → expect:
  - tx_valid from the cycle after start;
  - 113 consecutive bytes 0x00..0x70 with byte_idx 0..112;
  - done pulse one cycle after byte 0x70 is accepted;
  - busy falls the same cycle done rises.
- Same image, tx_ready pattern 1,0,0,1 repeating → tx_data/byte_idx stable during stalls; 113 transfers in order; no byte dropped or duplicated.
- After start, drive img_in to all 0xFF and img_valid=0 → stream still emits 0x00..0x70.
- start with img_valid=0 → err_not_ready high exactly 1 cycle; tx_valid and busy stay 0. A start during STREAM causes no effect.
- abort asserted when byte_idx=50 → tx_valid=0 next cycle, no done. Then restart → stream begins at byte 0x00. Also assert rst_n low at byte 20 → all outputs 0 immediately.
- With IMG_READBACK_CHECKSUM_EN, byte k = k → 114th byte = 0x70 (XOR of 0..112) with byte_idx=113, then done. With the macro undefined, the stream stops after 113 bytes.
